// File: rtl/arm_mem_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, grant encoding, default widths.
// No logic here; imported by mem_port_arbiter and its bench.
// No flow control of its own.
package arm_mem_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (I) and load/store (D) ports.
// Latency: one IDLE arbitration cycle, then ack combinationally with m_ready (min 1 cycle req->ack).
// Backpressure: requesters hold req/operands until ack; stall_f/stall_m flag the wait.
module mem_port_arbiter
    import arm_mem_pkg::*;
#(
    parameter int AW              = DEF_AW,
    parameter int DW              = DEF_DW,
    parameter int MAX_DATA_STREAK = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    output logic          stall_f,
    output logic          stall_m
);

    localparam int SW = (MAX_DATA_STREAK < 2) ? 1 : $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    arb_state_e    state;
    logic [SW-1:0] streak;
    logic          grant_vld;
    grant_e        grant;

    // D wins unless I has already been passed over MAX_DATA_STREAK times in a row.
    always_comb begin
        grant_vld = 1'b0;
        grant     = GRANT_I;
        if (d_req && (!i_req || (streak < STREAK_MAX))) begin
            grant_vld = 1'b1;
            grant     = GRANT_D;
        end else if (i_req) begin
            grant_vld = 1'b1;
            grant     = GRANT_I;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            streak  <= '0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        m_req <= 1'b1;
                        if (grant == GRANT_D) begin
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            state   <= BUSY_D;
                            if (i_req) begin
                                if (streak != STREAK_MAX) streak <= streak + 1'b1;
                            end else begin
                                streak <= '0;
                            end
                        end else begin
                            m_we    <= 1'b0;
                            m_addr  <= i_addr;
                            m_wdata <= '0;
                            state   <= BUSY_I;
                            streak  <= '0;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (m_ready) begin
                        m_req <= 1'b0;
                        m_we  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data is passed straight through; consumers qualify it with their ack.
    assign i_ack   = (state == BUSY_I) && m_ready;
    assign d_ack   = (state == BUSY_D) && m_ready;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;
    assign stall_f = i_req && !i_ack;
    assign stall_m = d_req && !d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small word-addressed memory model.
module tb_mem_port_arbiter;
    import arm_mem_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ready;
    logic          stall_f;
    logic          stall_m;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_count = 0;

    logic [DW-1:0] mem [64];

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DATA_STREAK(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .stall_f(stall_f), .stall_m(stall_m)
    );

    always #5 clk = ~clk;

    always_comb m_rdata = mem[m_addr[7:2]];

    always @(posedge clk) begin
        if (m_req && m_we && m_ready) begin
            mem[m_addr[7:2]] <= m_wdata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acks;
        int stall_m_seen;
        logic [1:0] exp_seq [6];
        logic [1:0] exp_streak [6];

        for (int k = 0; k < 64; k++) mem[k] = 32'h0;
        mem[0] = 32'h1111_0000;
        mem[1] = 32'h2222_0004;
        mem[2] = 32'hE3A0_800B;

        rst_n = 1'b0; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; m_ready = 1'b0;

        // Reset values, stall follows live requests.
        tick(); tick();
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_m_we", 32'(m_we), 32'd0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_m_wdata", m_wdata, 32'h0);
        chk("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
        i_req = 1'b1; d_req = 1'b1; m_ready = 1'b1; #1;
        chk("rst_stalls_live", {30'd0, stall_f, stall_m}, 32'd3);
        chk("rst_acks_ready", {30'd0, i_ack, d_ack}, 32'd0);
        i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;

        // Reset in the middle of a store leaves nothing behind.
        tick(); rst_n = 1'b1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h55;
        tick();
        chk("busyd_state", 32'(dut.state), 32'(BUSY_D));
        chk("busyd_m_req", 32'(m_req), 32'd1);
        chk("busyd_m_addr", m_addr, 32'h40);
        chk("busyd_stall_m", 32'(stall_m), 32'd1);
        rst_n = 1'b0; #1;
        chk("midrst_m_req", 32'(m_req), 32'd0);
        chk("midrst_d_ack", 32'(d_ack), 32'd0);
        chk("midrst_state", 32'(dut.state), 32'(IDLE));
        d_req = 1'b0; d_we = 1'b0;
        tick(); rst_n = 1'b1;
        i_req = 1'b1; i_addr = 32'h0; m_ready = 1'b1;
        tick();
        chk("postrst_m_addr", m_addr, 32'h0);
        chk("postrst_i_ack", 32'(i_ack), 32'd1);
        chk("postrst_i_rdata", i_rdata, 32'h1111_0000);
        i_req = 1'b0;
        tick(); m_ready = 1'b0;
        chk("postrst_idle", 32'(m_req), 32'd0);
        chk("no_write_abandoned", wr_count, 32'd0);

        // Single fetch with two BUSY cycles.
        i_req = 1'b1; i_addr = 32'h8; #1;
        chk("fetch_stall_idle", 32'(stall_f), 32'd1);
        tick();
        chk("fetch_m_addr", m_addr, 32'h8);
        chk("fetch_m_we", 32'(m_we), 32'd0);
        chk("fetch_busy1_ack", 32'(i_ack), 32'd0);
        chk("fetch_busy1_stall", 32'(stall_f), 32'd1);
        i_addr = 32'hC;
        tick();
        chk("fetch_busy2_m_addr", m_addr, 32'h8);
        m_ready = 1'b1; #1;
        chk("fetch_ack", 32'(i_ack), 32'd1);
        chk("fetch_rdata", i_rdata, 32'hE3A0_800B);
        chk("fetch_stall_ack", 32'(stall_f), 32'd0);
        chk("fetch_d_ack", 32'(d_ack), 32'd0);
        tick();
        i_req = 1'b0; #1;
        chk("fetch_ack_once", 32'(i_ack), 32'd0);
        chk("fetch_m_req_low", 32'(m_req), 32'd0);

        // Store then load of the same word.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h0000_000B;
        tick();
        chk("store_m_we", 32'(m_we), 32'd1);
        chk("store_m_wdata", m_wdata, 32'h0000_000B);
        chk("store_d_ack", 32'(d_ack), 32'd1);
        d_we = 1'b0; d_wdata = 32'hDEAD_BEEF;
        tick();
        chk("store_done_m_we", 32'(m_we), 32'd0);
        tick();
        chk("load_m_we", 32'(m_we), 32'd0);
        chk("load_m_addr", m_addr, 32'h20);
        chk("load_d_ack", 32'(d_ack), 32'd1);
        chk("load_d_rdata", d_rdata, 32'h0000_000B);
        chk("write_count", wr_count, 32'd1);
        d_req = 1'b0;
        tick();

        // Both requesters busy: D, D, I, D, D, I.
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b10;
        exp_seq[3] = 2'b01; exp_seq[4] = 2'b01; exp_seq[5] = 2'b10;
        exp_streak[0] = 2'd1; exp_streak[1] = 2'd2; exp_streak[2] = 2'd0;
        exp_streak[3] = 2'd1; exp_streak[4] = 2'd2; exp_streak[5] = 2'd0;
        i_req = 1'b1; i_addr = 32'h4; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        for (int t = 0; t < 6; t++) begin
            tick();
            chk($sformatf("arb_grant%0d", t), {30'd0, i_ack, d_ack}, 32'(exp_seq[t]));
            chk($sformatf("arb_streak%0d", t), 32'(dut.streak), 32'(exp_streak[t]));
            tick();
        end

        // Fetch-only traffic: one fetch every two cycles.
        d_req = 1'b0;
        acks = 0; stall_m_seen = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (i_ack) acks++;
            if (stall_m) stall_m_seen++;
        end
        chk("fetch_only_acks", acks, 32'd4);
        chk("fetch_only_stall_m", stall_m_seen, 32'd0);
        chk("fetch_only_streak", 32'(dut.streak), 32'd0);
        i_req = 1'b0;
        tick();

        // Operands changing while BUSY_D are ignored.
        m_ready = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        tick();
        d_addr = 32'h24; #1;
        chk("opchg_m_addr1", m_addr, 32'h20);
        tick();
        chk("opchg_m_addr2", m_addr, 32'h20);
        m_ready = 1'b1; #1;
        chk("opchg_d_ack", 32'(d_ack), 32'd1);
        chk("opchg_d_rdata", d_rdata, 32'h0000_000B);
        tick();
        d_req = 1'b0; m_ready = 1'b0; #1;
        chk("opchg_idle", 32'(m_req), 32'd0);
        chk("final_write_count", wr_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares a single-ported unified memory between the pipeline's fetch port (I) and its load/store port (D).
- Arbitrates between the two requesters and sequences each transaction over a variable-latency memory handshake.
- Produces the fetch and memory-stage stall signals that the hazard logic consumes.
- Sits in `top` between the pipelined processor and the unified memory, replacing separate imem/dmem.

Parameters:
- AW, 32, address width (byte address, passed through unmodified)
- DW, 32, data width
- MAX_DATA_STREAK, 2, consecutive D grants allowed while I is waiting before I is forced in (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr until i_ack
- i_addr  in  AW  fetch address
- i_rdata  out  DW  fetch data, valid when i_ack=1
- i_ack  out  1  fetch complete (one cycle per transaction)
- d_req  in  1  load/store request; held with d_we/d_addr/d_wdata until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data, valid when d_ack=1 and d_we=0
- d_ack  out  1  data transaction complete
- m_req  out  1  memory request, registered
- m_we  out  1  memory write enable, registered
- m_addr  out  AW  memory address, registered
- m_wdata  out  DW  memory write data, registered
- m_rdata  in  DW  memory read data, valid when m_ready=1
- m_ready  in  1  memory completes the current request this cycle
- stall_f  out  1  i_req & ~i_ack
- stall_m  out  1  d_req & ~d_ack

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D. Reset state is IDLE.
- Reset (async, rst_n=0):
  - state=IDLE, streak=0.
  - m_req, m_we, m_addr, m_wdata = 0.
  - i_ack, d_ack = 0; stall_f and stall_m follow the live i_req/d_req.
  - Reset mid-transaction abandons it; no ack is issued.
- IDLE grant decision, evaluated every IDLE cycle:
  - If d_req and (!i_req or streak < MAX_DATA_STREAK): grant D.
  - Else if i_req: grant I.
  - Else stay in IDLE.
- On a grant, at the clock edge:
  - Register the winner's address into m_addr.
  - For I: m_we=0, m_wdata=0.
  - For D: m_we=d_we, m_wdata=d_wdata.
  - Set m_req=1 and enter BUSY_I or BUSY_D.
- Streak counter, updated on each grant:
  - D grant while i_req=1: streak++, saturating at MAX_DATA_STREAK.
  - D grant while i_req=0: streak=0.
  - I grant: streak=0.
- BUSY_x:
  - m_* outputs hold stable until m_ready=1.
  - x_ack = m_ready (combinational); x_rdata = m_rdata (combinational).
  - The other requester's ack stays 0.
  - On the edge where m_ready=1: m_req=0 and m_we=0, return to IDLE.
- Timing and latency:
  - Minimum latency from request seen in IDLE to ack is 1 cycle (grant edge, then m_ready=1 on the first BUSY cycle).
  - Each transaction takes ≥2 cycles, including one IDLE arbitration cycle.
- Requester protocol: hold req and operands until the ack cycle. After the ack edge, either drop req or present a new request; a new request is arbitrated in the following IDLE cycle.
- Ignored inputs:
  - m_ready while in IDLE.
  - d_wdata when d_we=0.
  - Changes to a requester's operands while it is in BUSY (operands already registered).
- d_rdata for stores is don't-care. i_rdata and d_rdata may mirror m_rdata in all cycles; consumers qualify them with ack.
- No write is issued without d_req. No transaction is duplicated or dropped.

Decomposition:
- Package arm_mem_pkg holds:
  - typedef enum logic [1:0] arb_state_e {IDLE, BUSY_I, BUSY_D}
  - typedef enum logic grant_e {GRANT_I, GRANT_D}
  - default AW and DW constants
- The module stays flat. The grant/streak logic is small and does not justify its own sub-module.

Test Plan:
- Reset: rst_n=0 mid BUSY_D with m_ready=0 → next sample has m_req=0, d_ack=0, state IDLE; after release, a new i_req at addr 0x0 is granted.
- Single fetch: i_req=1, i_addr=0x8, memory m_ready after 2 BUSY cycles with m_rdata=0xE3A0800B → m_addr=0x8 and m_we=0; i_ack high for exactly one cycle with i_rdata=0xE3A0800B; stall_f=1 until that cycle.
- Store then load: d_req store addr 0x20 data 0x0000000B, then load addr 0x20 from a memory model → m_we=1 on the first transaction only; load returns d_rdata=0x0000000B.
- Simultaneous requests, MAX_DATA_STREAK=2: i_req and d_req both held continuously (D re-requests after each ack) → grant order D, D, I, D, D, I; streak resets on each I grant.
- Fetch-only traffic: d_req=0, i_req continuous with m_ready=1 → one fetch every 2 cycles; stall_m=0 throughout; streak stays 0.
- Operand change during BUSY_D: change d_addr from 0x20 to 0x24 after the grant → m_addr stays 0x20 until m_ready.
